// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and
// decoder-side valid/ready handshake. master = fetch_queue, slave = its environment.
interface fetch_queue_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [ADDR_W-1:0] imem_addr;
   logic              imem_req;
   logic [DATA_W-1:0] imem_data;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              dec_ready;
   logic              instr_valid;
   logic [DATA_W-1:0] instr;
   logic [ADDR_W-1:0] instr_pc;
   logic [CNT_W-1:0]  q_count;

   modport master (
      output imem_addr, imem_req,
      input  imem_data,
      input  redirect, redirect_pc,
      input  dec_ready,
      output instr_valid, instr, instr_pc, q_count
   );

   modport slave (
      input  imem_addr, imem_req,
      output imem_data,
      output redirect, redirect_pc,
      output dec_ready,
      input  instr_valid, instr, instr_pc, q_count
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues reads to a 1-cycle-latency
// instruction memory, buffers {word, pc} pairs in a small FIFO and hands them to
// decode over valid/ready. A redirect flushes everything and restarts fetch.
module fetch_queue #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic          CLK,
   input  logic          RST,
   fetch_queue_if.master bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] fetch_pc_reg;
   logic              pending_reg;
   logic [ADDR_W-1:0] pend_pc_reg;
   logic [PTR_W-1:0]  head_reg;
   logic [PTR_W-1:0]  tail_reg;
   logic [CNT_W-1:0]  count_reg;
   logic [DATA_W-1:0] instr_reg;
   logic [ADDR_W-1:0] instr_pc_reg;

   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [ADDR_W-1:0] mem_pc   [DEPTH];

   logic [CNT_W:0]    credit_used;
   logic              issue;
   logic              push;
   logic              pop;
   logic [PTR_W-1:0]  head_inc;

   // An in-flight read already owns a FIFO slot, so occupancy plus pending is the
   // credit in use; a pop in this cycle does not return credit until the next one.
   assign credit_used = {1'b0, count_reg} + {{CNT_W{1'b0}}, pending_reg};
   assign issue       = !RST && !bus.redirect && (credit_used < (CNT_W+1)'(DEPTH));
   assign push        = pending_reg && !bus.redirect;
   assign pop         = (count_reg != '0) && bus.dec_ready && !bus.redirect;
   assign head_inc    = head_reg + 1'b1;

   assign bus.imem_addr   = fetch_pc_reg;
   assign bus.imem_req    = issue;
   assign bus.instr_valid = (count_reg != '0);
   assign bus.instr       = instr_reg;
   assign bus.instr_pc    = instr_pc_reg;
   assign bus.q_count     = count_reg;

   // FIFO storage: write the returning memory word with its PC at the tail.
   always_ff @(posedge CLK) begin
      if (push) begin
         mem_data[tail_reg] <= bus.imem_data;
         mem_pc[tail_reg]   <= pend_pc_reg;
      end
   end

   // Fetch PC, in-flight tracking, FIFO pointers and the registered head view.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_pc_reg <= '0;
         pending_reg  <= 1'b0;
         pend_pc_reg  <= '0;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
         instr_reg    <= '0;
         instr_pc_reg <= '0;
      end else if (bus.redirect) begin
         // Drop the queue and the in-flight word; head view keeps its last value.
         fetch_pc_reg <= bus.redirect_pc;
         pending_reg  <= 1'b0;
         head_reg     <= '0;
         tail_reg     <= '0;
         count_reg    <= '0;
      end else begin
         if (issue) begin
            pending_reg  <= 1'b1;
            pend_pc_reg  <= fetch_pc_reg;
            fetch_pc_reg <= fetch_pc_reg + 1'b1;
         end else begin
            pending_reg  <= 1'b0;
         end

         if (push) begin
            tail_reg <= tail_reg + 1'b1;
         end
         if (pop) begin
            head_reg <= head_inc;
         end

         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase

         // Head view follows the entry that will be at the head after this edge;
         // when the queue drains it simply holds.
         if (pop) begin
            if (count_reg > CNT_W'(1)) begin
               instr_reg    <= mem_data[head_inc];
               instr_pc_reg <= mem_pc[head_inc];
            end else if (push) begin
               instr_reg    <= bus.imem_data;
               instr_pc_reg <= pend_pc_reg;
            end
         end else if (push && (count_reg == '0)) begin
            instr_reg    <= bus.imem_data;
            instr_pc_reg <= pend_pc_reg;
         end
      end
   end
endmodule
